// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: line synchroniser, start-edge detection, bit timing, frame FSM
// and a first-word fall-through receive FIFO with a valid/ready output handshake.
module uart_rx_param #(
   parameter int BAUD_DIV   = 434,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RX_Pin_In,
   input  logic                 RX_En_Sig,
   input  logic                 RX_Ready,
   output logic                 RX_Valid,
   output logic [DATA_BITS-1:0] RX_Data,
   output logic                 RX_Parity_Err,
   output logic                 RX_Frame_Err,
   output logic                 RX_Overrun_Sig,
   output logic                 RX_Busy
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int WW = DATA_BITS + 2;
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [1:0]    PAR_MODE  = 2'(PARITY);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_DATA       = 3'd2,
      ST_PARITY     = 3'd3,
      ST_STOP       = 3'd4,
      ST_BREAK_WAIT = 3'd5
   } state_t;

   function automatic logic parity_err_f(input logic [DATA_BITS-1:0] data, input logic pbit);
      logic x;
      x = ^{data, pbit};
      case (PAR_MODE)
         2'd1:    parity_err_f = ~x;
         2'd2:    parity_err_f = x;
         default: parity_err_f = 1'b0;
      endcase
   endfunction

   state_t                 state_r, state_n;
   logic [1:0]             sync_r;
   logic                   prev_r;
   logic [CW-1:0]          cnt_r;
   logic [3:0]             idx_r;
   logic [DATA_BITS-1:0]   shift_r;
   logic                   perr_r, ferr_r, push_r, push_s;
   logic [WW-1:0]          word_r, word_s;
   logic [WW-1:0]          mem_r [FIFO_DEPTH];
   logic [AW:0]            wr_ptr_r, rd_ptr_r;
   logic                   line_s, fall_s, tick_s, empty_s, full_s, pop_s, wr_en_s;
   logic [WW-1:0]          head_s;

   assign line_s = sync_r[1];
   assign fall_s = prev_r & ~line_s;
   assign tick_s = (cnt_r == {CW{1'b0}});

   // Two-flop synchroniser plus previous sample for falling-edge detection
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_r <= 2'b11;
         prev_r <= 1'b1;
      end else begin
         sync_r <= {sync_r[0], RX_Pin_In};
         prev_r <= sync_r[1];
      end
   end

   // Frame FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state_r <= ST_IDLE;
      else     state_r <= state_n;
   end

   // Frame FSM next-state and push decode
   always_comb begin
      state_n = state_r;
      push_s  = 1'b0;
      word_s  = {ferr_r | ~line_s, perr_r, shift_r};
      case (state_r)
         ST_IDLE: begin
            if (RX_En_Sig && fall_s) state_n = ST_START;
            else                     state_n = ST_IDLE;
         end
         ST_START: begin
            if (tick_s) state_n = line_s ? ST_IDLE : ST_DATA;
            else        state_n = ST_START;
         end
         ST_DATA: begin
            if (tick_s && idx_r == LAST_DATA) state_n = (PAR_MODE != 2'd0) ? ST_PARITY : ST_STOP;
            else                              state_n = ST_DATA;
         end
         ST_PARITY: begin
            if (tick_s) state_n = ST_STOP;
            else        state_n = ST_PARITY;
         end
         ST_STOP: begin
            if (tick_s && idx_r == LAST_STOP) begin
               push_s  = 1'b1;
               state_n = (ferr_r | ~line_s) ? ST_BREAK_WAIT : ST_IDLE;
            end else begin
               state_n = ST_STOP;
            end
         end
         ST_BREAK_WAIT: begin
            if (line_s) state_n = ST_IDLE;
            else        state_n = ST_BREAK_WAIT;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Bit timer, shift register and error accumulation; IDLE keeps the half-bit preload ready
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r   <= HALF_LOAD;
         idx_r   <= 4'd0;
         shift_r <= {DATA_BITS{1'b0}};
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
         push_r  <= 1'b0;
         word_r  <= {WW{1'b0}};
      end else begin
         cnt_r  <= tick_s ? FULL_LOAD : cnt_r - CNT_ONE;
         push_r <= push_s;
         word_r <= word_s;
         case (state_r)
            ST_IDLE: begin
               cnt_r  <= HALF_LOAD;
               idx_r  <= 4'd0;
               perr_r <= 1'b0;
               ferr_r <= 1'b0;
            end
            ST_DATA: begin
               if (tick_s) begin
                  shift_r <= {line_s, shift_r[DATA_BITS-1:1]};
                  idx_r   <= (idx_r == LAST_DATA) ? 4'd0 : idx_r + 4'd1;
               end
            end
            ST_PARITY: begin
               if (tick_s) perr_r <= parity_err_f(shift_r, line_s);
            end
            ST_STOP: begin
               if (tick_s) begin
                  ferr_r <= ferr_r | ~line_s;
                  idx_r  <= idx_r + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Pointers carry an extra wrap bit: equal = empty, equal index with differing wrap = full
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_s   = ~empty_s & RX_Ready;
   assign wr_en_s = push_r & (~full_s | pop_s);

   // FIFO pointer update
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // FIFO storage write
   always_ff @(posedge CLK) begin
      if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= word_r;
   end

   assign head_s         = mem_r[rd_ptr_r[AW-1:0]];
   assign RX_Valid       = ~empty_s;
   assign RX_Data        = RX_Valid ? head_s[DATA_BITS-1:0] : {DATA_BITS{1'b0}};
   assign RX_Parity_Err  = RX_Valid & head_s[DATA_BITS];
   assign RX_Frame_Err   = RX_Valid & head_s[DATA_BITS+1];
   assign RX_Overrun_Sig = push_r & full_s & ~pop_s;
   assign RX_Busy        = (state_r != ST_IDLE);

endmodule
